// File: rtl/div16_sequencer.sv
// Iterative 16-bit unsigned restoring-division controller. Each busy cycle it
// drives one operation into the shared saturating subtracter and consumes its
// difference and borrow. Divisors with the MSB set take a single compare step;
// divide-by-zero finishes straight from the accept edge.
module div16_sequencer #(
  parameter logic [15:0] DBZ_QUOTIENT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic [15:0] sub_a,
  output logic [15:0] sub_b,
  output logic        sub_cin,
  input  logic [15:0] sub_r,
  input  logic        sub_cout
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [W-1:0]    rem;
  logic [W-1:0]    quo;
  logic [W-1:0]    div_q;
  logic [CW-1:0]   count;

  logic [W-1:0]    partial;
  logic [W-1:0]    iter_rem;
  logic [W-1:0]    iter_quo;

  // Shift the next dividend bit into the partial remainder; it stays below
  // 2*divisor, so it always fits in W bits when the divisor MSB is clear.
  assign partial  = {rem[W-2:0], quo[W-1]};
  assign iter_rem = sub_cout ? partial : sub_r;
  assign iter_quo = {quo[W-2:0], ~sub_cout};

  // Subtracter operands are a pure decode of registered state, so the shared
  // unit only sees non-zero operands in CMP and ITER.
  assign sub_a   = (state == S_CMP)  ? quo :
                   (state == S_ITER) ? partial : '0;
  assign sub_b   = (state == S_CMP || state == S_ITER) ? div_q : '0;
  assign sub_cin = 1'b0;

  // Sequencer state, datapath registers and registered handshake/results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rem       <= '0;
      quo       <= '0;
      div_q     <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_q <= divisor;
            quo   <= dividend;
            rem   <= '0;
            count <= '0;
            dbz   <= 1'b0;
            if (divisor == '0) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              dbz       <= 1'b1;
              quotient  <= DBZ_QUOTIENT;
              remainder <= dividend;
            end else if (divisor[W-1]) begin
              state <= S_CMP;
              busy  <= 1'b1;
            end else begin
              state <= S_ITER;
              busy  <= 1'b1;
            end
          end
        end
        S_CMP: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!sub_cout) begin
            quotient  <= W'(1);
            remainder <= sub_r;
          end else begin
            quotient  <= '0;
            remainder <= quo;
          end
        end
        S_ITER: begin
          rem   <= iter_rem;
          quo   <= iter_quo;
          count <= count + CW'(1);
          if (count == LAST_ITER) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= iter_quo;
            remainder <= iter_rem;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16_sequencer.sv
// Directed bench for div16_sequencer with a behavioural saturating subtracter.
module tb_div16_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic [15:0] sub_a;
  logic [15:0] sub_b;
  logic        sub_cin;
  logic [15:0] sub_r;
  logic        sub_cout;

  int n_checks = 0;
  int n_errors = 0;

  div16_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_cin   (sub_cin),
    .sub_r     (sub_r),
    .sub_cout  (sub_cout)
  );

  // Shared saturating subtracter model.
  assign sub_cout = (sub_a < sub_b);
  assign sub_r    = (sub_a >= sub_b) ? 16'(sub_a - sub_b) : 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation at a falling edge and wait for done; optionally
  // re-pulse start with other operands at cycle glitch_at while busy.
  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                        input logic [15:0] exp_q, input logic [15:0] exp_r,
                        input logic exp_dbz, input int exp_lat, input int glitch_at);
    int lat;
    int busy_cyc;
    bit got;
    lat = 0;
    busy_cyc = 0;
    got = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      if (lat == glitch_at) begin
        start    = 1'b1;
        dividend = 16'd3;
        divisor  = 16'd1;
      end
      if (glitch_at > 0 && lat == glitch_at + 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) got = 1'b1;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, " dbz"}, 32'(dbz), 32'(exp_dbz));
    check({tag, " sub_ops_in_done"}, {sub_a, sub_b}, 32'd0);
    @(negedge clk);
    check({tag, " done_pulse_once"}, 32'(done), 32'd0);
    check({tag, " result_held"}, {quotient, remainder}, {exp_q, exp_r});
  endtask

  initial begin
    int lat;
    bit got;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    check("reset results", {quotient, remainder}, 32'd0);
    check("reset sub_ops", {sub_a, sub_b}, 32'd0);
    check("sub_cin", 32'(sub_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("100/7",       16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 17, 0);
    run_op("FFFF/8001",   16'hFFFF,  16'h8001,  16'd1,     16'h7FFE,  1'b0, 2,  0);
    run_op("7000/9000",   16'h7000,  16'h9000,  16'd0,     16'h7000,  1'b0, 2,  0);
    run_op("5/0",         16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1, 1,  0);
    run_op("9/3",         16'd9,     16'd3,     16'd3,     16'd0,     1'b0, 17, 0);
    run_op("FFFF/1",      16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0, 17, 0);
    run_op("0/1234",      16'd0,     16'h1234,  16'd0,     16'd0,     1'b0, 17, 0);
    run_op("100/7 glitch",16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 17, 5);

    // Hold start high through DONE: the next op is accepted in the following IDLE.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        dividend = 16'd200;
        divisor  = 16'd9;
      end
      if (done) got = 1'b1;
    end
    check("hold done_seen", 32'(got), 32'd1);
    check("hold first result", {quotient, remainder}, {16'd14, 16'd2});
    @(negedge clk);
    check("hold idle busy", 32'(busy), 32'd0);
    check("hold idle done", 32'(done), 32'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("hold reaccept busy", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    check("hold second done_seen", 32'(got), 32'd1);
    check("hold second latency", 32'(lat), 32'd17);
    check("hold second result", {quotient, remainder}, {16'd22, 16'd2});

    // Abort mid-ITER with reset; previous results are non-zero so clearing is visible.
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("abort pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort results", {quotient, remainder}, 32'd0);
    check("abort sub_ops", {sub_a, sub_b}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("abort no done", 32'(got), 32'd0);
    rst_n = 1'b1;
    run_op("200/9 post-reset", 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 17, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
